// File: rtl/nibble_enc_pkg.sv
// Shared constants and pure encode functions for the nibble dual encoder.
// Used by the combinational core and available to any consumer of the result.
package nibble_enc_pkg;

    localparam int DATA_W = 4;
    localparam int OUT_W  = 3;

    localparam logic MODE_POPCNT = 1'b0;
    localparam logic MODE_PRIO   = 1'b1;

    function automatic logic [OUT_W-1:0] popcnt4(input logic [DATA_W-1:0] d);
        logic [OUT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < DATA_W; i++) begin
            cnt = cnt + {2'b00, d[i]};
        end
        return cnt;
    endfunction

    // Result is {valid, msb_index}; all-zero input yields 3'b000.
    function automatic logic [OUT_W-1:0] prio4(input logic [DATA_W-1:0] d);
        logic [OUT_W-1:0] res;
        res = '0;
        if (d[3])      res = 3'b111;
        else if (d[2]) res = 3'b110;
        else if (d[1]) res = 3'b101;
        else if (d[0]) res = 3'b100;
        return res;
    endfunction

endpackage

// File: rtl/nibble_enc_comb.sv
// Combinational core: selects popcount or priority encoding of a nibble.
// Produces the next value captured by the output register.
module nibble_enc_comb
    import nibble_enc_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic              select,
    output logic [OUT_W-1:0]  next
);

    always_comb begin
        next = popcnt4(data);
        if (select == MODE_PRIO) begin
            next = prio4(data);
        end
    end

endmodule

// File: rtl/nibble_dual_encoder.sv
// Registered 4-bit dual-function encoder (popcount / priority encode).
// Inputs are only observed at the rising edge, so mid-cycle glitches never reach out.
module nibble_dual_encoder
    import nibble_enc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              select,
    output logic [OUT_W-1:0]  out
);

    logic [OUT_W-1:0] next;

    nibble_enc_comb u_comb (
        .data   (data),
        .select (select),
        .next   (next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= '0;
        end else begin
            out <= next;
        end
    end

endmodule

// File: tb/tb_nibble_dual_encoder.sv
// Self-checking bench for nibble_dual_encoder with an independent reference model.
// Directed scenarios followed by randomized stimulus including mid-cycle glitches.
module tb_nibble_dual_encoder;

    logic       clk;
    logic       rst;
    logic [3:0] data;
    logic       select;
    logic [2:0] out;

    int tests;
    int fails;

    nibble_dual_encoder dut (
        .clk    (clk),
        .rst    (rst),
        .data   (data),
        .select (select),
        .out    (out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: count ones, or locate the highest set bit, with plain arithmetic.
    function automatic logic [2:0] model(input logic [3:0] d, input logic s);
        int n;
        int top;
        n = 0;
        top = -1;
        for (int i = 0; i < 4; i++) begin
            if (d[i]) begin
                n = n + 1;
                top = i;
            end
        end
        if (!s) return 3'(n);
        if (top < 0) return 3'b000;
        return 3'(4 + top);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        data = 4'hF;
        select = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (out !== 3'b000) begin
            fails++;
            $display("FAIL reset_async: out=%b expected=%b", out, 3'b000);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (out !== 3'b000) begin
                fails++;
                $display("FAIL reset_hold[%0d]: out=%b expected=%b", i, out, 3'b000);
            end
        end
        rst = 1'b0;
        #1;
        tests++;
        if (out !== 3'b000) begin
            fails++;
            $display("FAIL reset_release: out=%b expected=%b", out, 3'b000);
        end
        tick();
        tests++;
        if (out !== model(4'hF, 1'b0)) begin
            fails++;
            $display("FAIL reset_first_edge: out=%b expected=%b", out, model(4'hF, 1'b0));
        end
    endtask

    task automatic test_sweep(input logic s);
        logic [2:0] exp;
        for (int d = 0; d < 16; d++) begin
            data = 4'(d);
            select = s;
            exp = model(4'(d), s);
            tick();
            tests++;
            if (out !== exp) begin
                fails++;
                $display("FAIL sweep sel=%0d data=%h: out=%b expected=%b", s, d, out, exp);
            end
        end
    endtask

    task automatic test_toggle();
        logic [3:0] pats [2];
        logic [2:0] exp;
        pats[0] = 4'b0110;
        pats[1] = 4'b1000;
        for (int p = 0; p < 2; p++) begin
            data = pats[p];
            for (int c = 0; c < 4; c++) begin
                select = c[0];
                exp = model(pats[p], c[0]);
                tick();
                tests++;
                if (out !== exp) begin
                    fails++;
                    $display("FAIL toggle data=%b sel=%0d: out=%b expected=%b",
                             pats[p], c[0], out, exp);
                end
            end
        end
    endtask

    task automatic test_glitch();
        logic [2:0] prev;
        logic [2:0] exp;
        data = 4'b1000;
        select = 1'b0;
        tick();
        prev = model(4'b1000, 1'b0);
        data = 4'b0011;
        select = 1'b0;
        #1;
        select = 1'b1;
        #1;
        select = 1'b0;
        #1;
        select = 1'b1;
        tests++;
        if (out !== prev) begin
            fails++;
            $display("FAIL glitch_hold: out=%b expected=%b", out, prev);
        end
        exp = 3'b101;
        tick();
        tests++;
        if (out !== exp) begin
            fails++;
            $display("FAIL glitch_result: out=%b expected=%b", out, exp);
        end
    endtask

    task automatic test_mid_reset();
        data = 4'b0111;
        select = 1'b0;
        tick();
        tests++;
        if (out !== 3'b011) begin
            fails++;
            $display("FAIL midrst_before: out=%b expected=%b", out, 3'b011);
        end
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if (out !== 3'b000) begin
            fails++;
            $display("FAIL midrst_clear: out=%b expected=%b", out, 3'b000);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (out !== 3'b000) begin
            fails++;
            $display("FAIL midrst_released: out=%b expected=%b", out, 3'b000);
        end
        tick();
        tests++;
        if (out !== 3'b011) begin
            fails++;
            $display("FAIL midrst_reload: out=%b expected=%b", out, 3'b011);
        end
    endtask

    task automatic test_random();
        logic [2:0] prev;
        logic [2:0] exp;
        logic [3:0] d;
        logic       s;
        prev = out;
        for (int i = 0; i < 300; i++) begin
            data = 4'($urandom_range(0, 15));
            select = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                #2;
                tests++;
                if (out !== prev) begin
                    fails++;
                    $display("FAIL random_hold[%0d]: out=%b expected=%b", i, out, prev);
                end
                data = 4'($urandom_range(0, 15));
                select = 1'($urandom_range(0, 1));
            end
            d = data;
            s = select;
            exp = model(d, s);
            tick();
            tests++;
            if (out !== exp) begin
                fails++;
                $display("FAIL random[%0d] data=%h sel=%0d: out=%b expected=%b",
                         i, d, s, out, exp);
            end
            prev = exp;
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        data = 4'h0;
        select = 1'b0;
        test_reset();
        test_sweep(1'b0);
        test_sweep(1'b1);
        test_toggle();
        test_glitch();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
